rom_arbiter: RTL and testbench
==============================

# rom_arbiter

Two-port round-robin arbiter that shares the single synchronous instruction/constant ROM between two requesters, for example the fetch stage (port 0) and a load/constant path (port 1). It accepts at most one read per cycle, drives the ROM read strobe and address, and tracks each in-flight read through the ROM's one-cycle latency. It returns every read word to the requester that issued it through a registered, held response. It sits between the requesters and the ROM instance and is the only block driving the ROM's read inputs.

## Interface
- AWIDTH, 8, ROM address width. Must match the ROM instance; the current ROM takes 8 address bits.
- DWIDTH, 16, ROM data width.

- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-high reset
- i_req0  input  1  port 0 read request; level, held until granted
- i_addr0  input  AWIDTH  port 0 read address
- o_gnt0  output  1  port 0 request accepted this cycle (combinational)
- o_rvalid0  output  1  one-cycle pulse: o_rdata0 carries a new word
- o_rdata0  output  DWIDTH  port 0 response word; held until the next port 0 response
- i_req1, i_addr1, o_gnt1, o_rvalid1, o_rdata1: same as port 0, for port 1
- o_rom_rd  output  1  ROM read strobe (ROM i_rd)
- o_rom_raddr  output  AWIDTH  ROM read address (ROM i_raddr)
- i_rom_rdata  input  DWIDTH  ROM read data (ROM o_rdata)

## Operation
- Arbitration is combinational in the request cycle:
  - Neither request: no grant.
  - One request: that port is granted.
  - Both request: the port other than `last` is granted.
- `last` is a 1-bit register holding the port granted most recently. It updates only on a grant. Reset value is 1, so port 0 wins the first contention.
- o_gnt0 and o_gnt1 are never high together.
- ROM drive:
  - o_rom_rd = o_gnt0 | o_gnt1.
  - o_rom_raddr = the address of the granted port, or 0 when there is no grant.
- A requester treats its request as consumed in any cycle its o_gntN is high. It may present a new address, or drop i_reqN, in the next cycle.
- In-flight tracking uses a two-stage pipeline:
  - Stage A registers {valid, port id} at grant.
  - In the cycle after stage A is valid, i_rom_rdata is captured into the response register of the tagged port, and that port's rvalid is set for one cycle.
- Only the tagged port's o_rdataN changes. The other port's o_rdataN holds its value.
- Back-to-back grants every cycle are supported, with up to 2 reads in flight. The arbiter has no backpressure: requesters must accept o_rvalidN whenever it pulses.
- Grants that alternate between ports return in issue order, with each word going to its own port.

## Timing
- Reset (asynchronous assert, released synchronously to clk by the system) clears:
  - stage A valid = 0
  - o_rvalid0 = o_rvalid1 = 0
  - o_rdata0 = o_rdata1 = 0
  - last = 1
- During reset, o_gntN and o_rom_rd still follow the combinational equations, but no tag is recorded.
- Read latency is 2 cycles:
  - Grant in cycle T.
  - ROM registers data at the end of T; i_rom_rdata is valid during T+1.
  - The arbiter registers it at the end of T+1; o_rvalidN is high and o_rdataN is valid during T+2.
- Throughput is 1 read per cycle in aggregate. Under continuous contention each port gets 1 grant every 2 cycles.
- Reset asserted mid-operation: all in-flight reads are discarded. No o_rvalidN fires for reads granted before or during reset, and the ROM data present in the first cycle after release is ignored.
- A request arriving in the same cycle a response pulses for that port is arbitrated normally. The two events are independent.
- Address wrap: addresses are used as-is and never incremented internally; 0xFF is a legal address.

## Test plan
- Reset then idle: assert rst with requests low -> all outputs 0, o_rom_rd = 0 for 10 cycles after release.
- Single read on port 0, using a ROM model where ROM[a] = {8'hA5, a}: i_req0 = 1 with i_addr0 = 8'h3C for 1 cycle (cycle T) -> o_gnt0 = 1 and o_rom_raddr = 8'h3C at T; o_rvalid0 = 1 with o_rdata0 = 16'hA53C at T+2; o_rvalid1 stays 0; o_rdata0 stays 16'hA53C afterwards.
- Contention: both ports request continuously, port 0 at 8'h10 and port 1 at 8'h20, from the first cycle after reset -> grants alternate 0,1,0,1. Responses alternate: o_rdata0 = 16'hA510 and o_rdata1 = 16'hA520, each pulsing every other cycle starting 2 cycles after the first grant.
- Streaming: port 1 alone with addresses 8'hFE, 8'hFF, 8'h00 on consecutive cycles -> 3 consecutive o_rvalid1 pulses carrying 16'hA5FE, 16'hA5FF, 16'hA500; o_rdata0 unchanged.
- Reset mid-flight: grant port 0 at cycle T and assert rst at T+1 -> no o_rvalid0 pulse occurs, and o_rdata0 = 0 after reset.
- Fairness after idle: port 1 granted alone, then an idle cycle, then both ports request -> port 0 is granted first.

Source files
------------

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM between two read ports.
// Each read is tagged with its port and its word is returned two cycles after the grant.
module rom_arbiter #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req0,
  input  logic [AWIDTH-1:0] i_addr0,
  output logic              o_gnt0,
  output logic              o_rvalid0,
  output logic [DWIDTH-1:0] o_rdata0,
  input  logic              i_req1,
  input  logic [AWIDTH-1:0] i_addr1,
  output logic              o_gnt1,
  output logic              o_rvalid1,
  output logic [DWIDTH-1:0] o_rdata1,
  output logic              o_rom_rd,
  output logic [AWIDTH-1:0] o_rom_raddr,
  input  logic [DWIDTH-1:0] i_rom_rdata
);

  // Handshake: a request is consumed in any cycle its grant is high; responses
  // have no backpressure and pulse rvalid for exactly one cycle.
  logic last;
  logic a_valid;
  logic a_port;

  // last == 1 means port 1 won most recently, so port 0 wins the next contention.
  always_comb begin
    o_gnt0 = 1'b0;
    o_gnt1 = 1'b0;
    if (i_req0 && i_req1) begin
      o_gnt0 = last;
      o_gnt1 = ~last;
    end else begin
      o_gnt0 = i_req0;
      o_gnt1 = i_req1;
    end
  end

  assign o_rom_rd    = o_gnt0 | o_gnt1;
  assign o_rom_raddr = o_gnt1 ? i_addr1 : (o_gnt0 ? i_addr0 : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (o_rom_rd) begin
      last <= o_gnt1;
    end
  end

  // Stage A covers the ROM's own cycle of latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_port  <= 1'b0;
    end else begin
      a_valid <= o_rom_rd;
      a_port  <= o_gnt1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rvalid0 <= 1'b0;
      o_rvalid1 <= 1'b0;
      o_rdata0  <= '0;
      o_rdata1  <= '0;
    end else begin
      o_rvalid0 <= a_valid & ~a_port;
      o_rvalid1 <= a_valid & a_port;
      if (a_valid && !a_port) o_rdata0 <= i_rom_rdata;
      if (a_valid && a_port)  o_rdata1 <= i_rom_rdata;
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed vector table, hand-written corner sequences and
// random traffic, all checked against a cycle-level reference model.
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [7:0]  addr0 = '0, addr1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, rom_rd;
  logic [15:0] rdata0, rdata1, rom_rdata;
  logic [7:0]  rom_raddr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rom_arbiter #(.AWIDTH(8), .DWIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .i_req0(req0), .i_addr0(addr0), .o_gnt0(gnt0), .o_rvalid0(rvalid0), .o_rdata0(rdata0),
    .i_req1(req1), .i_addr1(addr1), .o_gnt1(gnt1), .o_rvalid1(rvalid1), .o_rdata1(rdata1),
    .o_rom_rd(rom_rd), .o_rom_raddr(rom_raddr), .i_rom_rdata(rom_rdata)
  );

  // Synchronous ROM with ROM[a] = {8'hA5, a}
  initial rom_rdata = '0;
  always @(posedge clk) if (rom_rd) rom_rdata <= {8'hA5, rom_raddr};

  // Reference model: who won last, plus a scoreboard of outstanding reads.
  int          last_m = 1;
  int          cyc = 0;
  logic [15:0] exp_q[$];
  int          port_q[$];
  int          due_q[$];
  logic [15:0] rdata_m[2] = '{16'h0, 16'h0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One cycle: drive inputs, sample at the falling edge, advance the model.
  task automatic step(input logic r0, input logic r1, input logic [7:0] a0, input logic [7:0] a1);
    int          winner;
    logic [7:0]  waddr;
    logic        rv[2];
    req0 = r0; req1 = r1; addr0 = a0; addr1 = a1;
    @(negedge clk);
    if (rst) begin
      exp_q.delete(); port_q.delete(); due_q.delete();
      rdata_m[0] = '0; rdata_m[1] = '0;
      last_m = 1;
    end
    if (r0 && r1) winner = 1 - last_m;
    else if (r0)  winner = 0;
    else if (r1)  winner = 1;
    else          winner = -1;
    waddr = (winner == 0) ? a0 : (winner == 1) ? a1 : 8'h00;
    check("gnt0", gnt0, winner == 0);
    check("gnt1", gnt1, winner == 1);
    check("rom_rd", rom_rd, winner >= 0);
    check("rom_raddr", rom_raddr, waddr);
    rv[0] = 1'b0; rv[1] = 1'b0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      int p;
      void'(due_q.pop_front());
      p = port_q.pop_front();
      rdata_m[p] = exp_q.pop_front();
      rv[p] = 1'b1;
    end
    check("rvalid0", rvalid0, rv[0]);
    check("rvalid1", rvalid1, rv[1]);
    check("rdata0", rdata0, rdata_m[0]);
    check("rdata1", rdata1, rdata_m[1]);
    if (winner >= 0 && !rst) begin
      due_q.push_back(cyc + 2);
      port_q.push_back(winner);
      exp_q.push_back({8'hA5, waddr});
      last_m = winner;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 8'h00);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       r0, r1;
    logic [7:0] a0, a1;
    logic       g0, g1;
    logic [7:0] raddr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1, 1, 8'h10, 8'h20, 1, 0, 8'h10};
    vecs[1] = '{1, 1, 8'h10, 8'h20, 0, 1, 8'h20};
    vecs[2] = '{0, 1, 8'h00, 8'hFE, 0, 1, 8'hFE};
    vecs[3] = '{1, 1, 8'h33, 8'h44, 1, 0, 8'h33};
    vecs[4] = '{0, 0, 8'h55, 8'h66, 0, 0, 8'h00};
    vecs[5] = '{1, 0, 8'hFF, 8'h00, 1, 0, 8'hFF};
    vecs[6] = '{1, 1, 8'h01, 8'h02, 0, 1, 8'h02};
    vecs[7] = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00};

    @(posedge clk); #1;
    do_reset(3);
    check("reset_rdata0", rdata0, 16'h0);
    check("reset_rdata1", rdata1, 16'h0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, 8'h00);

    // Directed vector table, then drain
    for (int i = 0; i < 8; i++) begin
      req0 = vecs[i].r0; req1 = vecs[i].r1; addr0 = vecs[i].a0; addr1 = vecs[i].a1;
      #1;
      check("vec_gnt0", gnt0, vecs[i].g0);
      check("vec_gnt1", gnt1, vecs[i].g1);
      check("vec_raddr", rom_raddr, vecs[i].raddr);
      step(vecs[i].r0, vecs[i].r1, vecs[i].a0, vecs[i].a1);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 8'h00);

    // Single read on port 0
    do_reset(2);
    step(1'b1, 1'b0, 8'h3C, 8'h00);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    check("single_rdata0", rdata0, 16'hA53C);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 8'h00);
    check("single_hold", rdata0, 16'hA53C);

    // Continuous contention
    do_reset(2);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 8'h10, 8'h20);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    check("cont_rdata0", rdata0, 16'hA510);
    check("cont_rdata1", rdata1, 16'hA520);

    // Streaming on port 1 with address wrap
    step(1'b0, 1'b1, 8'h00, 8'hFE);
    step(1'b0, 1'b1, 8'h00, 8'hFF);
    step(1'b0, 1'b1, 8'h00, 8'h00);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    check("stream_rdata1", rdata1, 16'hA500);
    check("stream_rdata0", rdata0, 16'hA510);
    step(1'b0, 1'b0, 8'h00, 8'h00);

    // Reset mid-flight
    step(1'b1, 1'b0, 8'h77, 8'h00);
    do_reset(1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 8'h00);
    check("midflight_rdata0", rdata0, 16'h0);

    // Fairness after idle
    step(1'b0, 1'b1, 8'h00, 8'h11);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    req0 = 1'b1; req1 = 1'b1; addr0 = 8'h22; addr1 = 8'h33;
    #1;
    check("fair_gnt0", gnt0, 1'b1);
    step(1'b1, 1'b1, 8'h22, 8'h33);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 8'h00);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset($urandom_range(1, 2));
      else step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 8'h00);
    check("drain_empty", due_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
